bus_arbiter: RTL

Sequences ownership of the shared 32-bit addr/data tristate bus between the CPU units: Control_Center, ALU, RAM and ROM.
- Requesters ask for the bus; the arbiter grants exactly one owner at a time, round-robin.
- A turnaround gap of idle cycles follows every release, so two drivers never overlap on the bus.
- A hold limit stops a stuck owner from keeping the bus forever; the owner can set lock to override the limit.

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter_rr_pick.sv | 40 ++++
 rtl/bus_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | bus_arbiter_pkg : shared FSM encoding and requester index names    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  localparam int REQ_CC  = 0;
  localparam int REQ_ALU = 1;
  localparam int REQ_RAM = 2;
  localparam int REQ_ROM = 3;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// +--------------------------------------------------------------------+
// | rr_pick : combinational round-robin winner search after last_owner |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               found
);

  int cand;

  // Offsets 1..NUM_REQ visit every index once, ending on last_owner itself.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_owner) + off) % NUM_REQ;
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        win_idx                  = cand[IDX_W-1:0];
        win_oh[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// +--------------------------------------------------------------------+
// | bus_arbiter : round-robin bus ownership with turnaround and limit  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 15,
  parameter int IDX_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic               timeout_err
);

  localparam int              HC_W       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LIMIT = HC_W'(MAX_HOLD);
  localparam logic [1:0]      TURN_LAST  = 2'(TURNAROUND);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [1:0]         turn_q, turn_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               found;
  logic               do_grant;
  logic               do_release;

  assign elig = req & ~mask_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .elig       (elig),
    .last_owner (last_q),
    .win_oh     (win_oh),
    .win_idx    (win_idx),
    .found      (found)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    busy_d     = busy_q;
    to_d       = 1'b0;
    hold_d     = hold_q;
    turn_d     = turn_q;
    mask_d     = mask_q & req;
    do_grant   = 1'b0;
    do_release = 1'b0;

    case (state_q)
      ST_IDLE: begin
        do_grant = found;
      end
      ST_GRANT: begin
        // A voluntary drop on the limit edge wins over the forced release.
        if (!req[owner_q]) begin
          do_release = 1'b1;
        end else if (MAX_HOLD != 0 && hold_q == HOLD_LIMIT && !lock[owner_q]) begin
          do_release      = 1'b1;
          to_d            = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else if (hold_q < HOLD_LIMIT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          do_grant = found;
          if (!found) begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_release) begin
      state_d = ST_TURN;
      gnt_d   = '0;
      busy_d  = 1'b0;
      turn_d  = 2'd1;
    end

    if (do_grant) begin
      state_d = ST_GRANT;
      gnt_d   = win_oh;
      owner_d = win_idx;
      last_d  = win_idx;
      busy_d  = 1'b1;
      hold_d  = HC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      mask_q  <= mask_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

`default_nettype wire
